dvp_frame_ctrl: RTL and testbench

Frame-capture scheduler between the DVP raw capture stage and a two-buffer frame store. It arms on command and starts a capture only on a clean frame boundary. It applies frame decimation, assigns each captured frame to a free ping-pong buffer and generates linear write addresses. It checks frame geometry and hands completed frames to the downstream consumer with a buffer-ownership handshake.

---
 rtl/dvp_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dvp_frame_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_ctrl.sv
// Frame-capture scheduler between the DVP capture stage and a ping-pong frame store.
// It arms on command, decimates frames, assigns buffers, checks geometry and hands off frames.
module dvp_frame_ctrl #(
    parameter int H_ACT  = 1280,
    parameter int V_ACT  = 720,
    parameter int ADDR_W = 20
) (
    input  logic              PCLK,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_continuous,
    input  logic [3:0]        cfg_skip,
    input  logic              DataValid,
    input  logic              DataHs,
    input  logic              DataVs,
    input  logic [7:0]        DataPixel,
    input  logic [1:0]        buf_release,
    output logic              wr_en,
    output logic              wr_buf,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              done_buf,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int FRAME_PIX = H_ACT * V_ACT;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int PIX_W     = $clog2(H_ACT + 2);
    localparam int LINE_W    = $clog2(V_ACT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE
    } state_t;

    state_t            state;
    logic              vs_q;
    logic              hs_q;
    logic [1:0]        buf_full;
    logic              last_buf;
    logic [3:0]        skip_cnt;
    logic              stop_pending;
    logic [CNT_W-1:0]  addr;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              err;

    logic frame_start;
    logic frame_end;
    logic line_end;
    logic capturing;
    logic addr_full;
    logic pix_ovf;
    logic line_bad;
    logic err_now;
    logic lines_done_now;
    logic good_frame;
    logic any_free;
    logic pick_buf;

    assign frame_start = DataVs & ~vs_q;
    assign frame_end   = ~DataVs & vs_q;
    assign line_end    = ~DataHs & hs_q;
    assign capturing   = (state == S_CAPTURE);

    // A line closing on the same cycle as the frame still counts toward the verdict.
    assign addr_full      = (addr == CNT_W'(FRAME_PIX));
    assign pix_ovf        = capturing & DataValid & addr_full;
    assign line_bad       = capturing & line_end &
                            ((pix_cnt != PIX_W'(H_ACT)) | (line_cnt == LINE_W'(V_ACT)));
    assign err_now        = err | pix_ovf | line_bad;
    assign lines_done_now = (line_cnt == LINE_W'(V_ACT)) |
                            (line_end & (line_cnt == LINE_W'(V_ACT - 1)));
    assign good_frame     = ~err_now & lines_done_now;

    assign any_free = ~&buf_full;
    assign pick_buf = buf_full[~last_buf] ? last_buf : ~last_buf;

    // NOTE: all state lives in one clocked block using non-blocking assignments, so every
    // branch reads pre-edge values and later assignments in the block take priority.
    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= S_IDLE;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            buf_full     <= 2'b00;
            last_buf     <= 1'b1;
            skip_cnt     <= 4'd0;
            stop_pending <= 1'b0;
            addr         <= '0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            err          <= 1'b0;
            wr_en        <= 1'b0;
            wr_buf       <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 8'd0;
            frame_done   <= 1'b0;
            done_buf     <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
            drop_cnt     <= 8'd0;
        end else begin
            vs_q       <= DataVs;
            hs_q       <= DataHs;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            buf_full   <= buf_full & ~buf_release;

            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                        // The first frame after arming is captured; skipping applies between captures.
                        skip_cnt <= cfg_skip;
                    end
                end

                S_ARM: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (frame_start) begin
                        if (skip_cnt != cfg_skip) begin
                            skip_cnt <= skip_cnt + 4'd1;
                        end else if (any_free) begin
                            wr_buf   <= pick_buf;
                            addr     <= '0;
                            pix_cnt  <= '0;
                            line_cnt <= '0;
                            err      <= 1'b0;
                            skip_cnt <= 4'd0;
                            state    <= S_CAPTURE;
                        end else begin
                            if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                            skip_cnt <= 4'd0;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end

                    if (DataValid) begin
                        if (!addr_full) begin
                            wr_en   <= 1'b1;
                            wr_data <= DataPixel;
                            wr_addr <= addr[ADDR_W-1:0];
                            addr    <= addr + CNT_W'(1);
                        end
                        if (pix_cnt != PIX_W'(H_ACT + 1)) begin
                            pix_cnt <= pix_cnt + PIX_W'(1);
                        end
                    end

                    if (line_end) begin
                        pix_cnt <= '0;
                        if (line_cnt != LINE_W'(V_ACT)) begin
                            line_cnt <= line_cnt + LINE_W'(1);
                        end
                    end

                    if (err_now) begin
                        err <= 1'b1;
                    end

                    if (frame_end) begin
                        if (good_frame) begin
                            frame_done       <= 1'b1;
                            done_buf         <= wr_buf;
                            buf_full[wr_buf] <= 1'b1;
                            last_buf         <= wr_buf;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        if (cfg_continuous && !stop_pending && !stop) begin
                            state <= S_ARM;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                        stop_pending <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// Directed bench for dvp_frame_ctrl with a 4x3 frame geometry.
// Writes and handoff pulses are logged by a monitor; the directed sequence compares the log.
module tb_dvp_frame_ctrl;

    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 4;

    logic          PCLK;
    logic          Rst_n;
    logic          start;
    logic          stop;
    logic          cfg_continuous;
    logic [3:0]    cfg_skip;
    logic          DataValid;
    logic          DataHs;
    logic          DataVs;
    logic [7:0]    DataPixel;
    logic [1:0]    buf_release;
    logic          wr_en;
    logic          wr_buf;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          done_buf;
    logic          frame_err;
    logic          busy;
    logic [7:0]    drop_cnt;

    dvp_frame_ctrl #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
        .PCLK(PCLK),
        .Rst_n(Rst_n),
        .start(start),
        .stop(stop),
        .cfg_continuous(cfg_continuous),
        .cfg_skip(cfg_skip),
        .DataValid(DataValid),
        .DataHs(DataHs),
        .DataVs(DataVs),
        .DataPixel(DataPixel),
        .buf_release(buf_release),
        .wr_en(wr_en),
        .wr_buf(wr_buf),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_done(frame_done),
        .done_buf(done_buf),
        .frame_err(frame_err),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int wr_buf_q[$];
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int exp_data[$];
    int valid_cyc[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int last_done_buf = 0;
    logic [7:0] pix_seed = 8'hA0;

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (wr_en) begin
            wr_buf_q.push_back(int'(wr_buf));
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(int'(wr_data));
            wr_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt++;
            last_done_buf = int'(done_buf);
        end
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_buf_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        exp_data.delete();
        valid_cyc.delete();
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        tick(2);
        Rst_n = 1'b1;
        tick(2);
        done_cnt = 0;
        err_cnt = 0;
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic pulse_release(input logic [1:0] mask);
        buf_release = mask;
        tick();
        buf_release = 2'b00;
    endtask

    // One frame: optional short line, optional start/stop pulses, optional reset abort.
    task automatic send_frame(input int nlines, input int short_line, input bit mid_start,
                              input bit mid_stop, input int abort_line);
        DataVs = 1'b1;
        tick(2);
        if (mid_start) pulse_start();
        for (int l = 0; l < nlines; l++) begin
            DataHs = 1'b1;
            tick();
            for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) begin
                DataValid = 1'b1;
                DataPixel = pix_seed;
                exp_data.push_back(int'(pix_seed));
                valid_cyc.push_back(cyc);
                pix_seed = pix_seed + 8'd7;
                tick();
                if (abort_line == l && p == 1) begin
                    DataValid = 1'b0;
                    check("t6_wr_en_before_reset", wr_en, 1'b1);
                    Rst_n = 1'b0;
                    #1;
                    return;
                end
            end
            DataValid = 1'b0;
            if (mid_stop && l == 0) pulse_stop();
            else tick();
            DataHs = 1'b0;
            tick(2);
        end
        DataVs = 1'b0;
        tick(4);
    endtask

    task automatic check_capture(input string tag, input int exp_n, input int exp_buf);
        check({tag, "_nwr"}, wr_addr_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_buf%0d", tag, i), wr_buf_q[i], exp_buf);
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data[i]);
            check($sformatf("%s_lat%0d", tag, i), wr_cyc_q[i], valid_cyc[i] + 1);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_continuous = 1'b0;
        cfg_skip = 4'd0;
        DataValid = 1'b0;
        DataHs = 1'b0;
        DataVs = 1'b0;
        DataPixel = 8'd0;
        buf_release = 2'b00;
        tick(3);

        // Reset state
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_buf", wr_buf, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_done_buf", done_buf, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop_cnt", drop_cnt, 8'd0);
        Rst_n = 1'b1;
        tick(2);

        // Test 1: single shot, one good frame into buffer 0
        pulse_start();
        check("t1_busy_armed", busy, 1'b1);
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check_capture("t1", 12, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_buf", last_done_buf, 0);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_busy_idle", busy, 1'b0);

        // Test 2: continuous with skip 2, buffers released after each frame
        do_reset();
        cfg_continuous = 1'b1;
        cfg_skip = 4'd2;
        pulse_start();
        for (int f = 1; f <= 9; f++) begin
            clear_logs();
            send_frame(V, -1, 1'b0, 1'b0, -1);
            if (f == 1) check_capture("t2_f1", 12, 0);
            else if (f == 4) check_capture("t2_f4", 12, 1);
            else if (f == 7) check_capture("t2_f7", 12, 0);
            else check($sformatf("t2_f%0d_nwr", f), wr_addr_q.size(), 0);
            pulse_release(2'b11);
        end
        check("t2_done_cnt", done_cnt, 3);
        check("t2_busy_cont", busy, 1'b1);
        pulse_stop();
        tick();
        check("t2_busy_stopped", busy, 1'b0);

        // Test 3: no release, both buffers fill and frames drop
        do_reset();
        cfg_continuous = 1'b1;
        cfg_skip = 4'd0;
        pulse_start();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check_capture("t3_f1", 12, 0);
        clear_logs();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check_capture("t3_f2", 12, 1);
        check("t3_done_buf_f2", last_done_buf, 1);
        clear_logs();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check("t3_f3_nwr", wr_addr_q.size(), 0);
        check("t3_drop_1", drop_cnt, 8'd1);
        clear_logs();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check("t3_f4_nwr", wr_addr_q.size(), 0);
        check("t3_drop_2", drop_cnt, 8'd2);
        pulse_release(2'b01);
        clear_logs();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check_capture("t3_f5", 12, 0);
        check("t3_done_cnt", done_cnt, 3);
        check("t3_done_buf_f5", last_done_buf, 0);
        check("t3_drop_final", drop_cnt, 8'd2);
        pulse_stop();

        // Test 4: short line, then a frame with one extra line
        do_reset();
        cfg_continuous = 1'b0;
        pulse_start();
        send_frame(V, 1, 1'b0, 1'b0, -1);
        check_capture("t4_short", 11, 0);
        check("t4_short_err", err_cnt, 1);
        check("t4_short_done", done_cnt, 0);
        check("t4_short_busy", busy, 1'b0);
        clear_logs();
        pulse_start();
        send_frame(V + 1, -1, 1'b0, 1'b0, -1);
        check_capture("t4_tall", 12, 0);
        check("t4_tall_err", err_cnt, 2);
        check("t4_tall_done", done_cnt, 0);

        // Test 5: start mid-frame waits for the next frame; stop lets the frame finish
        do_reset();
        cfg_continuous = 1'b1;
        send_frame(V, -1, 1'b1, 1'b0, -1);
        check("t5_midstart_nwr", wr_addr_q.size(), 0);
        check("t5_midstart_busy", busy, 1'b1);
        clear_logs();
        send_frame(V, -1, 1'b0, 1'b1, -1);
        check_capture("t5_stop", 12, 0);
        check("t5_stop_done", done_cnt, 1);
        check("t5_stop_busy", busy, 1'b0);
        clear_logs();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check("t5_idle_nwr", wr_addr_q.size(), 0);

        // Test 6: reset in the middle of a capture
        do_reset();
        cfg_continuous = 1'b0;
        pulse_start();
        send_frame(V, -1, 1'b0, 1'b0, 1);
        check("t6_async_wr_en", wr_en, 1'b0);
        check("t6_async_wr_addr", wr_addr, 4'd0);
        check("t6_async_wr_data", wr_data, 8'd0);
        check("t6_async_busy", busy, 1'b0);
        DataHs = 1'b0;
        DataVs = 1'b0;
        tick(2);
        Rst_n = 1'b1;
        tick(6);
        check("t6_no_done", done_cnt, 0);
        check("t6_no_err", err_cnt, 0);
        check("t6_idle_busy", busy, 1'b0);
        clear_logs();
        pulse_start();
        send_frame(V, -1, 1'b0, 1'b0, -1);
        check_capture("t6_after", 12, 0);
        check("t6_after_done", done_cnt, 1);
        check("t6_after_done_buf", last_done_buf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
